ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 6-stage 16-bit pipeline.
- Consumes F1/F2/FCCR from the Ex forwarding unit and selects operands and flags.
- Runs ALU, address, branch and jump logic, and registers results into the EX/MEM pipeline register.
- Owns the architectural carry/zero (CCR) register, updated at writeback.

Parameters:
- W, 16, datapath width
- OPW, 6, opcode width ({op[3:0], cz[1:0]})

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold EX/MEM register and CCR update
- flush  in  1  insert bubble into EX/MEM
- rr_valid  in  1  instruction in regread_ex is valid
- rr_op  in  6  regread_ex opcode
- rr_regA/rr_regB/rr_regC  in  3 each  register specifiers
- rr_dataA/rr_dataB  in  W each  register-file read values
- rr_imm  in  9  raw immediate field
- rr_pc  in  W  instruction PC
- F1/F2  in  3 each  operand forward selects
- FCCR  in  2  flag forward select
- mem_wb_alu, mem_wb_mem, mem_wb_pc1  in  W each  MEM/WB result, load data, PC+1
- mem_wb_flags  in  2  MEM/WB {C,Z}
- mem_wb_commit  in  1  MEM/WB writes CCR this cycle
- ex_mem_valid  out  1  EX/MEM holds a valid instruction
- ex_mem_op  out  6  EX/MEM opcode
- ex_mem_regA/ex_mem_regB/ex_mem_regC  out  3 each  EX/MEM register specifiers
- ex_mem_alu  out  W  ALU result, LHI value, or address
- ex_mem_store  out  W  store data
- ex_mem_pc1  out  W  PC+1
- ex_mem_flags  out  2  computed {C,Z}
- ex_mem_CCR_write  out  1  active-low: 0 = result and flags commit, 1 = suppressed
- pc_redirect  out  1  taken BEQ/JAL/JLR, combinational
- pc_target  out  W  redirect target
- ccr  out  2  architectural {C,Z}

Behaviour:
- Operand select, F1→opA and F2→opB:
  - 0 and 4 → rr_data
  - 1 → ex_mem_alu
  - 2 → mem_wb_alu
  - 3 → mem_wb_mem
  - 5 → ex_mem_alu (LHI value)
  - 6 → mem_wb_alu
  - 7 → mem_wb_pc1
- Flag select, FCCR: 0 → ccr, 1 → ex_mem_flags, 2 → mem_wb_flags, 3 → ccr.
- Immediates: sext6 = rr_imm[5:0] sign-extended; sext9 = rr_imm[8:0] sign-extended; LHI value = {rr_imm, 7'b0}.
- ADD/ADC/ADZ: opA+opB, 17-bit sum; C = bit 16, Z = (sum[15:0]==0).
- ADI: opA+sext6; result destined for regB; C and Z as for ADD.
- NDU/NDC/NDZ: ~(opA&opB); Z updated, C passes through the selected flag.
- Conditional commit: ADC commits only if selected C=1; ADZ/NDZ only if selected Z=1; NDC only if C=1. A suppressed instruction sets ex_mem_CCR_write=1 and ex_mem_flags = selected flags unchanged.
- LHI: ex_mem_alu = LHI value; flags unchanged.
- LW/SW: address = opB+sext6; ex_mem_store = opA; flags unchanged.
- BEQ: redirect if opA==opB; target = rr_pc+sext6.
- JAL: always redirect; target = rr_pc+sext9; pc1 = rr_pc+1.
- JLR: target = opB; pc1 = rr_pc+1.
- pc_redirect is asserted only when rr_valid & ~stall & ~flush.
- EX/MEM register, on posedge clk:
  - flush → valid=0, ex_mem_CCR_write=1, other fields don't-care-held.
  - else stall → hold all fields.
  - else capture; valid = rr_valid.
  - flush wins over stall.
  - An invalid instruction is always captured with ex_mem_CCR_write=1.
- CCR: on posedge, if mem_wb_commit & ~stall, ccr ← mem_wb_flags. A stall freezes CCR.
- All arithmetic wraps modulo 2^16.
- Reset, asynchronous and asserted mid-operation:
  - ex_mem_valid=0, ex_mem_CCR_write=1.
  - All data, op, reg and flag outputs 0.
  - ccr=2'b00.
  - Deassertion is synchronous to the next clk edge.

Test Plan:
- Forwarding: ADD r3=r1+r2 with rr_dataA=5, ex_mem_alu=0x0010, F1=1, F2=0, rr_dataB=3 → ex_mem_alu=0x0013, flags=00, CCR_write=0.
- Carry and zero: ADD opA=0xFFFF, opB=0x0001 → ex_mem_alu=0x0000, flags C=1 Z=1. Next cycle, ADC with FCCR=1 → commits, CCR_write=0.
- Suppressed conditional: ADZ with FCCR=0, ccr=00 → CCR_write=1, flags=00, ccr unchanged after mem_wb_commit=0.
- Branch: BEQ opA=opB=7, rr_pc=0x0020, imm=0x3E (−2) → pc_redirect=1, pc_target=0x001E. Repeat with flush=1 → pc_redirect=0 and bubble captured.
- Stall and flush: stall=1 for 3 cycles → EX/MEM and ccr frozen. stall=1 with flush=1 → valid=0 next edge.
- Mid-cycle reset: assert reset_n=0 between edges → outputs clear immediately; ccr=00, CCR_write=1.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 6-stage 16-bit pipeline: operand/flag forwarding, ALU,
// address and branch/jump resolution, EX/MEM pipeline register and the CCR.
module ex_stage #(
  parameter int W   = 16,
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           stall,
  input  logic           flush,
  input  logic           rr_valid,
  input  logic [OPW-1:0] rr_op,
  input  logic [2:0]     rr_regA,
  input  logic [2:0]     rr_regB,
  input  logic [2:0]     rr_regC,
  input  logic [W-1:0]   rr_dataA,
  input  logic [W-1:0]   rr_dataB,
  input  logic [8:0]     rr_imm,
  input  logic [W-1:0]   rr_pc,
  input  logic [2:0]     F1,
  input  logic [2:0]     F2,
  input  logic [1:0]     FCCR,
  input  logic [W-1:0]   mem_wb_alu,
  input  logic [W-1:0]   mem_wb_mem,
  input  logic [W-1:0]   mem_wb_pc1,
  input  logic [1:0]     mem_wb_flags,
  input  logic           mem_wb_commit,
  output logic           ex_mem_valid,
  output logic [OPW-1:0] ex_mem_op,
  output logic [2:0]     ex_mem_regA,
  output logic [2:0]     ex_mem_regB,
  output logic [2:0]     ex_mem_regC,
  output logic [W-1:0]   ex_mem_alu,
  output logic [W-1:0]   ex_mem_store,
  output logic [W-1:0]   ex_mem_pc1,
  output logic [1:0]     ex_mem_flags,
  output logic           ex_mem_CCR_write,
  output logic           pc_redirect,
  output logic [W-1:0]   pc_target,
  output logic [1:0]     ccr
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  logic           valid_q, valid_d;
  logic [OPW-1:0] op_q, op_d;
  logic [2:0]     rega_q, rega_d, regb_q, regb_d, regc_q, regc_d;
  logic [W-1:0]   alu_q, alu_d, store_q, store_d, pc1_q, pc1_d;
  logic [1:0]     flags_q, flags_d;
  logic           cw_q, cw_d;
  logic [1:0]     ccr_q, ccr_d;

  logic [W-1:0]   op_a_s, op_b_s, sext6_s, sext9_s, lhi_s, nand_s, res_s, target_s;
  logic [W:0]     sum_s, adi_s;
  logic [1:0]     sel_flags_s, new_flags_s;
  logic           supp_s, redirect_s;

  function automatic logic [W-1:0] fwd_sel(input logic [2:0] f, input logic [W-1:0] rr,
                                           input logic [W-1:0] exm, input logic [W-1:0] wba,
                                           input logic [W-1:0] wbm, input logic [W-1:0] wbpc);
    case (f)
      3'd1, 3'd5: fwd_sel = exm;
      3'd2, 3'd6: fwd_sel = wba;
      3'd3:       fwd_sel = wbm;
      3'd7:       fwd_sel = wbpc;
      default:    fwd_sel = rr;
    endcase
  endfunction

  // Operand and flag selection plus the execute datapath.
  always_comb begin
    op_a_s  = fwd_sel(F1, rr_dataA, alu_q, mem_wb_alu, mem_wb_mem, mem_wb_pc1);
    op_b_s  = fwd_sel(F2, rr_dataB, alu_q, mem_wb_alu, mem_wb_mem, mem_wb_pc1);
    case (FCCR)
      2'd1:    sel_flags_s = flags_q;
      2'd2:    sel_flags_s = mem_wb_flags;
      default: sel_flags_s = ccr_q;
    endcase
    sext6_s = {{(W-6){rr_imm[5]}}, rr_imm[5:0]};
    sext9_s = {{(W-9){rr_imm[8]}}, rr_imm};
    lhi_s   = W'({rr_imm, 7'b0000000});
    sum_s   = {1'b0, op_a_s} + {1'b0, op_b_s};
    adi_s   = {1'b0, op_a_s} + {1'b0, sext6_s};
    nand_s  = ~(op_a_s & op_b_s);

    res_s       = sum_s[W-1:0];
    new_flags_s = sel_flags_s;
    supp_s      = 1'b0;
    redirect_s  = 1'b0;
    target_s    = '0;
    case (rr_op[5:2])
      OP_ADD: begin
        new_flags_s = {sum_s[W], (sum_s[W-1:0] == '0)};
        case (rr_op[1:0])
          2'b10:   supp_s = ~sel_flags_s[1];
          2'b01:   supp_s = ~sel_flags_s[0];
          default: supp_s = 1'b0;
        endcase
      end
      OP_ADI: begin
        res_s       = adi_s[W-1:0];
        new_flags_s = {adi_s[W], (adi_s[W-1:0] == '0)};
      end
      OP_NDU: begin
        res_s       = nand_s;
        new_flags_s = {sel_flags_s[1], (nand_s == '0)};
        case (rr_op[1:0])
          2'b10:   supp_s = ~sel_flags_s[1];
          2'b01:   supp_s = ~sel_flags_s[0];
          default: supp_s = 1'b0;
        endcase
      end
      OP_LHI:        res_s = lhi_s;
      OP_LW, OP_SW:  res_s = op_b_s + sext6_s;
      // Control transfers carry their target down the pipe in the ALU slot.
      OP_BEQ: begin
        target_s   = rr_pc + sext6_s;
        redirect_s = (op_a_s == op_b_s);
        res_s      = target_s;
      end
      OP_JAL: begin
        target_s   = rr_pc + sext9_s;
        redirect_s = 1'b1;
        res_s      = target_s;
      end
      OP_JLR: begin
        target_s   = op_b_s;
        redirect_s = 1'b1;
        res_s      = target_s;
      end
      default: res_s = sum_s[W-1:0];
    endcase
    if (supp_s) begin
      new_flags_s = sel_flags_s;
    end else begin
      new_flags_s = new_flags_s;
    end
  end

  assign pc_redirect = redirect_s & rr_valid & ~stall & ~flush;
  assign pc_target   = target_s;

  // Next-state for the EX/MEM register and the CCR; flush beats stall.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    regc_d  = regc_q;
    alu_d   = alu_q;
    store_d = store_q;
    pc1_d   = pc1_q;
    flags_d = flags_q;
    cw_d    = cw_q;
    if (flush) begin
      valid_d = 1'b0;
      cw_d    = 1'b1;
    end else if (!stall) begin
      valid_d = rr_valid;
      op_d    = rr_op;
      rega_d  = rr_regA;
      regb_d  = rr_regB;
      regc_d  = rr_regC;
      alu_d   = res_s;
      store_d = op_a_s;
      pc1_d   = rr_pc + W'(1);
      flags_d = new_flags_s;
      cw_d    = ~rr_valid | supp_s;
    end else begin
      valid_d = valid_q;
    end
    if (mem_wb_commit && !stall) begin
      ccr_d = mem_wb_flags;
    end else begin
      ccr_d = ccr_q;
    end
  end

  // EX/MEM pipeline register and architectural CCR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      rega_q  <= 3'd0;
      regb_q  <= 3'd0;
      regc_q  <= 3'd0;
      alu_q   <= '0;
      store_q <= '0;
      pc1_q   <= '0;
      flags_q <= 2'b00;
      cw_q    <= 1'b1;
      ccr_q   <= 2'b00;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      regc_q  <= regc_d;
      alu_q   <= alu_d;
      store_q <= store_d;
      pc1_q   <= pc1_d;
      flags_q <= flags_d;
      cw_q    <= cw_d;
      ccr_q   <= ccr_d;
    end
  end

  assign ex_mem_valid     = valid_q;
  assign ex_mem_op        = op_q;
  assign ex_mem_regA      = rega_q;
  assign ex_mem_regB      = regb_q;
  assign ex_mem_regC      = regc_q;
  assign ex_mem_alu       = alu_q;
  assign ex_mem_store     = store_q;
  assign ex_mem_pc1       = pc1_q;
  assign ex_mem_flags     = flags_q;
  assign ex_mem_CCR_write = cw_q;
  assign ccr              = ccr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases then random traffic, checked
// against an arithmetic reference model of the execute stage.
module tb_ex_stage;
  logic        clk = 1'b0, reset_n = 1'b1, stall = 1'b0, flush = 1'b0, rr_valid = 1'b0;
  logic [5:0]  rr_op = 6'd0;
  logic [2:0]  rr_regA = 3'd0, rr_regB = 3'd0, rr_regC = 3'd0, F1 = 3'd0, F2 = 3'd0;
  logic [15:0] rr_dataA = 16'd0, rr_dataB = 16'd0, rr_pc = 16'd0;
  logic [8:0]  rr_imm = 9'd0;
  logic [1:0]  FCCR = 2'd0, mem_wb_flags = 2'd0;
  logic [15:0] mem_wb_alu = 16'd0, mem_wb_mem = 16'd0, mem_wb_pc1 = 16'd0;
  logic        mem_wb_commit = 1'b0;
  logic        ex_mem_valid, ex_mem_CCR_write, pc_redirect;
  logic [5:0]  ex_mem_op;
  logic [2:0]  ex_mem_regA, ex_mem_regB, ex_mem_regC;
  logic [15:0] ex_mem_alu, ex_mem_store, ex_mem_pc1, pc_target;
  logic [1:0]  ex_mem_flags, ccr;

  ex_stage #(.W(16), .OPW(6)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .rr_valid(rr_valid),
    .rr_op(rr_op), .rr_regA(rr_regA), .rr_regB(rr_regB), .rr_regC(rr_regC),
    .rr_dataA(rr_dataA), .rr_dataB(rr_dataB), .rr_imm(rr_imm), .rr_pc(rr_pc),
    .F1(F1), .F2(F2), .FCCR(FCCR), .mem_wb_alu(mem_wb_alu), .mem_wb_mem(mem_wb_mem),
    .mem_wb_pc1(mem_wb_pc1), .mem_wb_flags(mem_wb_flags), .mem_wb_commit(mem_wb_commit),
    .ex_mem_valid(ex_mem_valid), .ex_mem_op(ex_mem_op), .ex_mem_regA(ex_mem_regA),
    .ex_mem_regB(ex_mem_regB), .ex_mem_regC(ex_mem_regC), .ex_mem_alu(ex_mem_alu),
    .ex_mem_store(ex_mem_store), .ex_mem_pc1(ex_mem_pc1), .ex_mem_flags(ex_mem_flags),
    .ex_mem_CCR_write(ex_mem_CCR_write), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .ccr(ccr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [5:0] op; logic [2:0] ra, rb, rc;
    logic [15:0] alu, st, pc1; logic [1:0] fl; logic cw; logic [1:0] ccr;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0, n_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] f, input logic [15:0] rr);
    case (f)
      3'd1, 3'd5: return int'(m.alu);
      3'd2, 3'd6: return int'(mem_wb_alu);
      3'd3:       return int'(mem_wb_mem);
      3'd7:       return int'(mem_wb_pc1);
      default:    return int'(rr);
    endcase
  endfunction

  // Reference model: evaluate the instruction on the current inputs, check the
  // combinational redirect, then advance the model across one clock edge.
  task automatic cycle();
    int a, b, s6, s9, sum, res, pc, tgt;
    logic [1:0] fs, nf;
    bit supp, br, redir;
    a  = pick(F1, rr_dataA);
    b  = pick(F2, rr_dataB);
    pc = int'(rr_pc);
    fs = (FCCR == 2'd1) ? m.fl : (FCCR == 2'd2) ? mem_wb_flags : m.ccr;
    s6 = int'(rr_imm[5:0]) - (rr_imm[5] ? 64 : 0);
    s9 = int'(rr_imm) - (rr_imm[8] ? 512 : 0);
    nf = fs; supp = 0; br = 0; redir = 0; tgt = 0; res = 0;
    case (rr_op[5:2])
      4'd0: begin
        sum = a + b; res = sum % 65536; nf = {sum > 65535, res == 0};
        supp = (rr_op[1:0] == 2'b10 && !fs[1]) || (rr_op[1:0] == 2'b01 && !fs[0]);
      end
      4'd1: begin
        sum = a + ((s6 + 65536) % 65536); res = sum % 65536; nf = {sum > 65535, res == 0};
      end
      4'd2: begin
        res = (~(a & b)) & 65535; nf = {fs[1], res == 0};
        supp = (rr_op[1:0] == 2'b10 && !fs[1]) || (rr_op[1:0] == 2'b01 && !fs[0]);
      end
      4'd3:       res = int'(rr_imm) * 128;
      4'd4, 4'd5: res = (b + s6 + 65536) % 65536;
      4'd12: begin br = 1; tgt = (pc + s6 + 65536) % 65536; redir = (a == b); res = tgt; end
      4'd8:  begin br = 1; tgt = (pc + s9 + 65536) % 65536; redir = 1; res = tgt; end
      4'd9:  begin br = 1; tgt = b; redir = 1; res = tgt; end
      default: res = (a + b) % 65536;
    endcase
    if (supp) nf = fs;
    #1;
    chk("pc_redirect", pc_redirect, redir && rr_valid && !stall && !flush);
    if (br) chk("pc_target", pc_target, tgt);
    if (flush) begin
      m.v = 0; m.cw = 1;
    end else if (!stall) begin
      m.v = rr_valid; m.op = rr_op; m.ra = rr_regA; m.rb = rr_regB; m.rc = rr_regC;
      m.alu = res[15:0]; m.st = a[15:0]; m.pc1 = rr_pc + 16'd1; m.fl = nf;
      m.cw = !rr_valid || supp;
    end
    if (mem_wb_commit && !stall) m.ccr = mem_wb_flags;
    @(posedge clk);
    q.push_back(m);
  endtask

  task automatic set_in(input logic [5:0] op, input logic [15:0] da, input logic [15:0] db,
                        input logic [8:0] imm, input logic [15:0] pc, input logic [2:0] f1,
                        input logic [2:0] f2, input logic [1:0] fccr);
    rr_valid = 1; stall = 0; flush = 0; mem_wb_commit = 0;
    rr_op = op; rr_dataA = da; rr_dataB = db; rr_imm = imm; rr_pc = pc;
    F1 = f1; F2 = f2; FCCR = fccr;
    rr_regA = 3'd1; rr_regB = 3'd2; rr_regC = 3'd3;
  endtask

  task automatic model_reset();
    m = '0; m.cw = 1'b1; q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, ex_mem_valid, 1'b0);
    chk({tag, "_ccr_write"}, ex_mem_CCR_write, 1'b1);
    chk({tag, "_ccr"}, ccr, 2'b00);
    chk({tag, "_alu"}, ex_mem_alu, 16'h0000);
    chk({tag, "_store"}, ex_mem_store, 16'h0000);
    chk({tag, "_pc1"}, ex_mem_pc1, 16'h0000);
    chk({tag, "_op_regs_flags"}, {ex_mem_op, ex_mem_regA, ex_mem_regB, ex_mem_regC, ex_mem_flags}, 32'd0);
  endtask

  // Monitor: one scoreboard entry per clock edge, compared just after it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        chk("valid", ex_mem_valid, e.v);
        chk("ccr_write", ex_mem_CCR_write, e.cw);
        chk("ccr", ccr, e.ccr);
        if (e.v) begin
          chk("op", ex_mem_op, e.op);
          chk("regs", {ex_mem_regA, ex_mem_regB, ex_mem_regC}, {e.ra, e.rb, e.rc});
          chk("alu", ex_mem_alu, e.alu);
          chk("store", ex_mem_store, e.st);
          chk("pc1", ex_mem_pc1, e.pc1);
          chk("flags", ex_mem_flags, e.fl);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [5:0] ops [13] = '{6'b000000, 6'b000010, 6'b000001, 6'b000011, 6'b000100,
                           6'b001000, 6'b001010, 6'b001001, 6'b001100, 6'b010000,
                           6'b010100, 6'b110000, 6'b100000};

  initial begin : driver
    model_reset();
    #1 reset_n = 0;
    #2 chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1; mon_en = 1;

    // Forwarding from EX/MEM.
    @(negedge clk); set_in(6'b000000, 16'h0008, 16'h0008, 9'd0, 16'h0100, 3'd0, 3'd0, 2'd0); cycle();
    @(negedge clk); set_in(6'b000000, 16'h0005, 16'h0003, 9'd0, 16'h0101, 3'd1, 3'd0, 2'd0); cycle();
    @(negedge clk);
    chk("fwd_alu", ex_mem_alu, 16'h0013);
    chk("fwd_flags_cw", {ex_mem_flags, ex_mem_CCR_write}, 3'b000);
    // Carry and zero, then ADC using the forwarded flags.
    set_in(6'b000000, 16'hFFFF, 16'h0001, 9'd0, 16'h0102, 3'd0, 3'd0, 2'd0); cycle();
    @(negedge clk);
    chk("carry_alu", ex_mem_alu, 16'h0000);
    chk("carry_flags", ex_mem_flags, 2'b11);
    set_in(6'b000010, 16'h1234, 16'h0001, 9'd0, 16'h0103, 3'd0, 3'd0, 2'd1); cycle();
    @(negedge clk);
    chk("adc_commit", ex_mem_CCR_write, 1'b0);
    // ADZ suppressed by ccr Z=0.
    set_in(6'b000001, 16'h0001, 16'h0002, 9'd0, 16'h0104, 3'd0, 3'd0, 2'd0); cycle();
    @(negedge clk);
    chk("adz_suppressed", {ex_mem_CCR_write, ex_mem_flags}, 3'b100);
    // Taken BEQ, then the same with flush.
    set_in(6'b110000, 16'h0007, 16'h0007, 9'h03E, 16'h0020, 3'd0, 3'd0, 2'd0);
    #1 chk("beq_redirect", pc_redirect, 1'b1);
    chk("beq_target", pc_target, 16'h001E);
    cycle();
    @(negedge clk); set_in(6'b110000, 16'h0007, 16'h0007, 9'h03E, 16'h0020, 3'd0, 3'd0, 2'd0);
    flush = 1; cycle();
    @(negedge clk); chk("beq_flush_bubble", ex_mem_valid, 1'b0);
    // Stall for three cycles with a pending commit, then stall+flush, then commit.
    set_in(6'b000000, 16'h0100, 16'h0200, 9'd0, 16'h0030, 3'd0, 3'd0, 2'd0); cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(6'b001000, 16'hAAAA, 16'h5555, 9'd0, 16'h0040, 3'd0, 3'd0, 2'd0);
      stall = 1; mem_wb_commit = 1; mem_wb_flags = 2'b10; cycle();
    end
    @(negedge clk); chk("stall_held_alu", ex_mem_alu, 16'h0300);
    set_in(6'b000000, 16'h0001, 16'h0001, 9'd0, 16'h0050, 3'd0, 3'd0, 2'd0);
    stall = 1; flush = 1; cycle();
    @(negedge clk); chk("stall_flush_bubble", ex_mem_valid, 1'b0);
    set_in(6'b001100, 16'h0000, 16'h0000, 9'h1FF, 16'h0060, 3'd0, 3'd0, 2'd0);
    mem_wb_commit = 1; mem_wb_flags = 2'b10; cycle();
    @(negedge clk); chk("ccr_commit", ccr, 2'b10);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rr_valid      = ($urandom_range(0, 99) < 85);
      stall         = ($urandom_range(0, 99) < 10);
      flush         = ($urandom_range(0, 99) < 8);
      rr_op         = ops[$urandom_range(0, 12)];
      rr_regA       = 3'($urandom); rr_regB = 3'($urandom); rr_regC = 3'($urandom);
      rr_dataA      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rr_dataB      = ($urandom_range(0, 7) == 0) ? rr_dataA : 16'($urandom);
      rr_imm        = 9'($urandom);
      rr_pc         = 16'($urandom);
      F1            = 3'($urandom); F2 = 3'($urandom); FCCR = 2'($urandom);
      mem_wb_alu    = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      mem_wb_mem    = 16'($urandom);
      mem_wb_pc1    = 16'($urandom);
      mem_wb_flags  = 2'($urandom);
      mem_wb_commit = 1'($urandom);
      cycle();
    end

    // Reset asserted between edges clears state immediately.
    @(negedge clk);
    mon_en = 0;
    #2 reset_n = 0;
    #1 chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_n = 1; mon_en = 1;
    set_in(6'b000100, 16'h7FFF, 16'h0000, 9'h001, 16'h0070, 3'd0, 3'd0, 2'd0); cycle();
    @(negedge clk);
    chk("post_reset_adi", {ex_mem_alu, ex_mem_flags}, {16'h8000, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
